// File: rtl/draw_bg_scroll_if.sv
// vga_if: VGA timing/pixel bundle passed between pipeline stages.
//   vcount, hcount : 11-bit pixel counters (active plus blanking area)
//   vsync, hsync   : sync pulses
//   vblnk, hblnk   : blanking flags
//   rgb            : 12-bit 4:4:4 colour, driven only by drawing stages
// Modports: 'in' for a consumer of timing, 'out' for a producer of timing + rgb.
interface vga_if;
    logic [10:0] vcount;
    logic [10:0] hcount;
    logic        vsync;
    logic        hsync;
    logic        vblnk;
    logic        hblnk;
    logic [11:0] rgb;

    modport in  (input  vcount, hcount, vsync, hsync, vblnk, hblnk);
    modport out (output vcount, hcount, vsync, hsync, vblnk, hblnk, rgb);
endinterface

// File: rtl/draw_bg_scroll.sv
// draw_bg_scroll: background stage of the VGA pipeline. Draws border lines,
// a ground band, a sky and N_CLOUDS round clouds that scroll horizontally
// with wrap-around, with day/night colours. Two-cycle latency on all fields.
// Ports:
//   clk        : pixel clock
//   rst_n      : asynchronous active-low reset
//   scroll_en  : 1 = clouds advance on frame ticks, 0 = freeze
//   night_mode : 1 = night colour set
//   vga_in     : timing from the upstream stage
//   vga_out    : timing delayed by 2 cycles plus generated rgb
module draw_bg_scroll #(
    parameter int          HOR_PIXELS    = 1024,
    parameter int          VER_PIXELS    = 768,
    parameter int          GROUND_Y      = 501,
    parameter int          N_CLOUDS      = 4,
    parameter int          CLOUD_X0      = 100,
    parameter int          CLOUD_SPACING = 256,
    parameter int          CLOUD_Y0      = 100,
    parameter int          CLOUD_DY      = 100,
    parameter int          CLOUD_R2      = 900,
    parameter int          SCROLL_DIV    = 2,
    parameter logic [11:0] SKY_DAY       = 12'h00F,
    parameter logic [11:0] SKY_NIGHT     = 12'h004,
    parameter logic [11:0] CLOUD_DAY     = 12'hFFF,
    parameter logic [11:0] CLOUD_NIGHT   = 12'h888,
    parameter logic [11:0] GROUND_RGB    = 12'h0F0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scroll_en,
    input  logic night_mode,
    vga_if.in    vga_in,
    vga_if.out   vga_out
);

    localparam int CW   = 11;                 // counter width of vga_if
    localparam int DW   = CW + 1;             // distance width, holds HOR_PIXELS
    localparam int SW   = 2 * DW + 1;         // squared-distance sum width
    localparam int OW   = (HOR_PIXELS > 1) ? $clog2(HOR_PIXELS) : 1;
    localparam int DIVW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;

    typedef enum logic [2:0] {
        CLS_BLANK  = 3'd0,  // must be the reset value so a cleared pipe gives rgb 0
        CLS_TOP    = 3'd1,
        CLS_BOTTOM = 3'd2,
        CLS_LEFT   = 3'd3,
        CLS_RIGHT  = 3'd4,
        CLS_GROUND = 3'd5,
        CLS_SKY    = 3'd6
    } pix_class_t;

    function automatic int cloud_base(input int k);
        return (CLOUD_X0 + k * CLOUD_SPACING) % HOR_PIXELS;
    endfunction

    // ---------------- frame tick and scroll offset ----------------
    logic            r_vblnk_d;
    logic [DIVW-1:0] r_div_cnt;
    logic [OW-1:0]   r_offset;
    logic            w_tick;

    assign w_tick = vga_in.vblnk & ~r_vblnk_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vblnk_d <= 1'b0;
            r_div_cnt <= '0;
            r_offset  <= '0;
        end else begin
            r_vblnk_d <= vga_in.vblnk;
            if (w_tick && scroll_en) begin
                if (r_div_cnt == DIVW'(SCROLL_DIV - 1)) begin
                    r_div_cnt <= '0;
                    r_offset  <= (r_offset == OW'(HOR_PIXELS - 1)) ? '0 : r_offset + 1'b1;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- stage 1: distances and class ----------------
    logic [DW-1:0] w_cx_sum [N_CLOUDS];
    logic [DW-1:0] w_cx     [N_CLOUDS];
    logic [DW-1:0] w_cy     [N_CLOUDS];
    logic [DW-1:0] w_adx    [N_CLOUDS];
    logic [DW-1:0] w_dx     [N_CLOUDS];
    logic [DW-1:0] w_dy     [N_CLOUDS];
    logic [DW-1:0] w_h;
    logic [DW-1:0] w_v;
    pix_class_t    w_class;

    assign w_h = DW'(vga_in.hcount);
    assign w_v = DW'(vga_in.vcount);

    always_comb begin
        for (int unsigned k = 0; k < N_CLOUDS; k++) begin
            // base < HOR and offset < HOR, so one conditional subtract is the modulo
            w_cx_sum[k] = DW'(cloud_base(int'(k))) + DW'(r_offset);
            w_cx[k]     = (w_cx_sum[k] >= DW'(HOR_PIXELS)) ? w_cx_sum[k] - DW'(HOR_PIXELS)
                                                           : w_cx_sum[k];
            w_cy[k]     = DW'(CLOUD_Y0 + (((k % 2) == 1) ? CLOUD_DY : 0));
            w_adx[k]    = (w_h >= w_cx[k]) ? w_h - w_cx[k] : w_cx[k] - w_h;
            // shorter way round the screen, so clouds straddle the edges;
            // hcount in blanking can exceed HOR_PIXELS, those pixels are black anyway
            if (w_adx[k] >= DW'(HOR_PIXELS)) begin
                w_dx[k] = w_adx[k];
            end else if (w_adx[k] > DW'(HOR_PIXELS) - w_adx[k]) begin
                w_dx[k] = DW'(HOR_PIXELS) - w_adx[k];
            end else begin
                w_dx[k] = w_adx[k];
            end
            w_dy[k]     = (w_v >= w_cy[k]) ? w_v - w_cy[k] : w_cy[k] - w_v;
        end
    end

    always_comb begin
        w_class = CLS_SKY;
        if (vga_in.hblnk || vga_in.vblnk) begin
            w_class = CLS_BLANK;
        end else if (vga_in.vcount == '0) begin
            w_class = CLS_TOP;
        end else if (vga_in.vcount == CW'(VER_PIXELS - 1)) begin
            w_class = CLS_BOTTOM;
        end else if (vga_in.hcount == '0) begin
            w_class = CLS_LEFT;
        end else if (vga_in.hcount == CW'(HOR_PIXELS - 1)) begin
            w_class = CLS_RIGHT;
        end else if (vga_in.vcount >= CW'(GROUND_Y)) begin
            w_class = CLS_GROUND;
        end
    end

    logic [CW-1:0] r_s1_vcount;
    logic [CW-1:0] r_s1_hcount;
    logic          r_s1_vsync;
    logic          r_s1_hsync;
    logic          r_s1_vblnk;
    logic          r_s1_hblnk;
    pix_class_t    r_s1_class;
    logic          r_s1_night;
    logic [DW-1:0] r_s1_dx [N_CLOUDS];
    logic [DW-1:0] r_s1_dy [N_CLOUDS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vcount <= '0;
            r_s1_hcount <= '0;
            r_s1_vsync  <= 1'b0;
            r_s1_hsync  <= 1'b0;
            r_s1_vblnk  <= 1'b0;
            r_s1_hblnk  <= 1'b0;
            r_s1_class  <= CLS_BLANK;
            r_s1_night  <= 1'b0;
            for (int unsigned k = 0; k < N_CLOUDS; k++) begin
                r_s1_dx[k] <= '0;
                r_s1_dy[k] <= '0;
            end
        end else begin
            r_s1_vcount <= vga_in.vcount;
            r_s1_hcount <= vga_in.hcount;
            r_s1_vsync  <= vga_in.vsync;
            r_s1_hsync  <= vga_in.hsync;
            r_s1_vblnk  <= vga_in.vblnk;
            r_s1_hblnk  <= vga_in.hblnk;
            r_s1_class  <= w_class;
            r_s1_night  <= night_mode;
            for (int unsigned k = 0; k < N_CLOUDS; k++) begin
                r_s1_dx[k] <= w_dx[k];
                r_s1_dy[k] <= w_dy[k];
            end
        end
    end

    // ---------------- stage 2: cloud hit and colour ----------------
    logic [SW-1:0] w_d2 [N_CLOUDS];
    logic          w_hit;
    logic [11:0]   w_rgb;

    always_comb begin
        w_hit = 1'b0;
        for (int unsigned k = 0; k < N_CLOUDS; k++) begin
            w_d2[k] = SW'(r_s1_dx[k]) * SW'(r_s1_dx[k]) + SW'(r_s1_dy[k]) * SW'(r_s1_dy[k]);
            if (w_d2[k] <= SW'(CLOUD_R2)) begin
                w_hit = 1'b1;
            end
        end
    end

    always_comb begin
        w_rgb = '0;
        case (r_s1_class)
            CLS_BLANK:  w_rgb = '0;
            CLS_TOP:    w_rgb = 12'hFF0;
            CLS_BOTTOM: w_rgb = 12'hF00;
            CLS_LEFT:   w_rgb = 12'h0F0;
            CLS_RIGHT:  w_rgb = 12'h00F;
            CLS_GROUND: w_rgb = GROUND_RGB;
            CLS_SKY: begin
                if (w_hit) begin
                    w_rgb = r_s1_night ? CLOUD_NIGHT : CLOUD_DAY;
                end else begin
                    w_rgb = r_s1_night ? SKY_NIGHT : SKY_DAY;
                end
            end
            default:    w_rgb = '0;
        endcase
    end

    logic [CW-1:0] r_s2_vcount;
    logic [CW-1:0] r_s2_hcount;
    logic          r_s2_vsync;
    logic          r_s2_hsync;
    logic          r_s2_vblnk;
    logic          r_s2_hblnk;
    logic [11:0]   r_s2_rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_vcount <= '0;
            r_s2_hcount <= '0;
            r_s2_vsync  <= 1'b0;
            r_s2_hsync  <= 1'b0;
            r_s2_vblnk  <= 1'b0;
            r_s2_hblnk  <= 1'b0;
            r_s2_rgb    <= '0;
        end else begin
            r_s2_vcount <= r_s1_vcount;
            r_s2_hcount <= r_s1_hcount;
            r_s2_vsync  <= r_s1_vsync;
            r_s2_hsync  <= r_s1_hsync;
            r_s2_vblnk  <= r_s1_vblnk;
            r_s2_hblnk  <= r_s1_hblnk;
            r_s2_rgb    <= w_rgb;
        end
    end

    assign vga_out.vcount = r_s2_vcount;
    assign vga_out.hcount = r_s2_hcount;
    assign vga_out.vsync  = r_s2_vsync;
    assign vga_out.hsync  = r_s2_hsync;
    assign vga_out.vblnk  = r_s2_vblnk;
    assign vga_out.hblnk  = r_s2_hblnk;
    assign vga_out.rgb    = r_s2_rgb;

endmodule

// File: tb/tb_draw_bg_scroll.sv
// tb_draw_bg_scroll: directed self-checking bench for draw_bg_scroll.
// dut_a uses SCROLL_DIV=2, dut_b uses SCROLL_DIV=1; both share vga_in,
// reset and night_mode, with separate scroll enables.
module tb_draw_bg_scroll;

    logic clk         = 1'b0;
    logic rst_n       = 1'b0;
    logic scroll_en_a = 1'b0;
    logic scroll_en_b = 1'b0;
    logic night_mode  = 1'b0;

    int checks   = 0;
    int failures = 0;

    vga_if vin ();
    vga_if vout_a ();
    vga_if vout_b ();

    draw_bg_scroll #(.SCROLL_DIV(2)) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .scroll_en  (scroll_en_a),
        .night_mode (night_mode),
        .vga_in     (vin.in),
        .vga_out    (vout_a.out)
    );

    draw_bg_scroll #(.SCROLL_DIV(1)) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .scroll_en  (scroll_en_b),
        .night_mode (night_mode),
        .vga_in     (vin.in),
        .vga_out    (vout_b.out)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb,
                         input logic hs, input logic vs);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = hb;
        vin.vblnk  = vb;
        vin.hsync  = hs;
        vin.vsync  = vs;
    endtask

    // Drive one pixel and check rgb of the selected DUT two cycles later.
    task automatic pix(input string tag, input bit sel_b, input int h, input int v,
                       input logic hb, input logic [11:0] exp);
        @(negedge clk);
        drive(h, v, hb, 1'b0, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check_eq(tag, sel_b ? vout_b.rgb : vout_a.rgb, exp);
    endtask

    // Each call produces n distinct vblnk rising edges.
    task automatic frames(input int n);
        repeat (n) begin
            @(negedge clk);
            vin.vblnk = 1'b1;
            @(negedge clk);
            vin.vblnk = 1'b0;
        end
    endtask

    initial begin
        vin.rgb = '0;
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset with random inputs: every output field stays 0
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(int'($urandom_range(0, 1343)), int'($urandom_range(0, 805)),
                  1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            #1;
            check_eq("rst_fields_a", {vout_a.vcount, vout_a.hcount, vout_a.vsync, vout_a.hsync,
                                      vout_a.vblnk, vout_a.hblnk, vout_a.rgb}, 64'd0);
        end

        // Release; first pixel appears after exactly 2 cycles
        @(negedge clk);
        rst_n = 1'b1;
        drive(100, 100, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_eq("lat1_rgb", vout_a.rgb, 12'h000);
        check_eq("lat1_hsync", vout_a.hsync, 1'b0);
        @(negedge clk);
        check_eq("lat2_rgb", vout_a.rgb, 12'hFFF);
        check_eq("lat2_hsync", vout_a.hsync, 1'b1);
        check_eq("lat2_vsync", vout_a.vsync, 1'b1);
        check_eq("lat2_hcount", vout_a.hcount, 11'd100);

        // Offset 0: cloud edges, borders, ground, blanking
        pix("edge_in",    1'b0, 130, 100, 1'b0, 12'hFFF);
        pix("edge_out",   1'b0, 131, 100, 1'b0, 12'h00F);
        pix("cloud1",     1'b0, 356, 200, 1'b0, 12'hFFF);
        pix("ground",     1'b0, 300, 600, 1'b0, 12'h0F0);
        pix("left",       1'b0,   0, 300, 1'b0, 12'h0F0);
        pix("right",      1'b0, 1023, 300, 1'b0, 12'h00F);
        pix("top",        1'b0, 500,   0, 1'b0, 12'hFF0);
        pix("bottom",     1'b0, 500, 767, 1'b0, 12'hF00);
        pix("hblnk",      1'b0, 130, 100, 1'b1, 12'h000);

        // Divider of 2: two ticks move dut_a by one pixel
        scroll_en_a = 1'b1;
        frames(2);
        pix("div_in",     1'b0, 131, 100, 1'b0, 12'hFFF);
        pix("div_out",    1'b0,  70, 100, 1'b0, 12'h00F);
        pix("b_frozen",   1'b1, 131, 100, 1'b0, 12'h00F);

        // Long vblnk counts one tick, next frame completes step to offset 2
        @(negedge clk);
        vin.vblnk = 1'b1;
        repeat (20) @(negedge clk);
        vin.vblnk = 1'b0;
        frames(1);
        pix("hold_in",    1'b0,  72, 100, 1'b0, 12'hFFF);
        pix("hold_out",   1'b0,  71, 100, 1'b0, 12'h00F);

        // Freeze over 10 frames
        scroll_en_a = 1'b0;
        frames(10);
        pix("frz_in",     1'b0,  72, 100, 1'b0, 12'hFFF);
        pix("frz_out",    1'b0,  71, 100, 1'b0, 12'h00F);

        // Night colours
        night_mode = 1'b1;
        pix("night_cld",  1'b0, 100, 100, 1'b0, 12'h888);
        pix("night_sky",  1'b0, 500,  10, 1'b0, 12'h004);
        night_mode = 1'b0;

        // Wrap on dut_b (divider 1): offset 920 puts cloud0 at x=1020
        scroll_en_b = 1'b1;
        frames(920);
        pix("wrap_in",    1'b1,   5, 100, 1'b0, 12'hFFF);
        pix("wrap_out",   1'b1,  50, 100, 1'b0, 12'h00F);
        frames(104);
        pix("wrap0_in",   1'b1, 100, 100, 1'b0, 12'hFFF);
        pix("wrap0_out",  1'b1, 131, 100, 1'b0, 12'h00F);
        scroll_en_b = 1'b0;

        // Mid-line asynchronous reset; dut_a offset is 2 beforehand
        pix("pre_rst",    1'b0, 131, 100, 1'b0, 12'hFFF);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rgb_a", vout_a.rgb, 12'h000);
        check_eq("async_rgb_b", vout_b.rgb, 12'h000);
        check_eq("async_hcnt", vout_a.hcount, 11'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(131, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check_eq("post_lat1", vout_a.rgb, 12'h000);
        @(negedge clk);
        check_eq("post_off0", vout_a.rgb, 12'h00F);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
